conv_layer_sequencer: RTL and testbench

Controller that sequences one convolution layer across the weight cache, the Img2Col stream engine and the systolic array. For each output-channel tile it triggers a weight load and waits for the cache to report ready. It then enables activation streaming until the Img2Col engine signals end of pass, and drains the systolic array. It iterates over all tiles and reports completion. It sits between the layer-level control registers and the `Weight_Cache` / `Img2ColStreamV2` / `Tile` instances.

---
 rtl/conv_layer_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer
//
// Runs one convolution layer, one output-channel tile at a time. For each
// tile the sequencer:
//   1. pulses the weight cache start and waits for the tile weights,
//   2. lets the Img2Col engine stream activations into the systolic array
//      until the engine reports end of pass,
//   3. waits a fixed number of cycles while the systolic array drains.
// When the last tile has drained, it pulses done.
//
// Optional feature (macro CONV_SEQ_PERF_CNT_EN):
//   Adds the stall_cycles and stream_cycles performance counters. These are
//   absent in the default build.
//
// Parameters:
//   TILE_W        width of tile_count / tile_idx
//   DRAIN_W       width of drain_cycles and the drain counter
//   WAIT_TIMEOUT  maximum number of cycles spent waiting for weights
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           one-cycle layer start; only accepted while idle
//   tile_count      tiles per layer (0 behaves as 1), sampled on start
//   drain_cycles    systolic flush length (0 behaves as 1), sampled on start
//   weight_start    one-cycle pulse to the weight cache
//   weight_cached   level from the weight cache: weights resident
//   img2col_start   level, high while activations stream
//   layer_end       one-cycle pulse from Img2Col: pass complete
//   array_valid_en  gate for the Img2Col valid into the systolic array
//   busy            high whenever the sequencer is not idle
//   tile_idx        0-based index of the current tile
//   done            one-cycle pulse when the layer completes
//   error           sticky; set on a weight timeout or a stray layer_end,
//                   cleared by rst or an accepted start
//   stall_cycles    (perf build) cycles spent waiting for weights
//   stream_cycles   (perf build) cycles spent streaming
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module conv_layer_sequencer #(
    parameter int unsigned TILE_W       = 8,
    parameter int unsigned DRAIN_W      = 16,
    parameter int unsigned WAIT_TIMEOUT = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TILE_W-1:0]  tile_count,
    input  logic [DRAIN_W-1:0] drain_cycles,
    output logic               weight_start,
    input  logic               weight_cached,
    output logic               img2col_start,
    input  logic               layer_end,
    output logic               array_valid_en,
    output logic               busy,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               done,
    output logic               error
`ifdef CONV_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        stream_cycles
`endif
);

    // Wide enough to hold WAIT_TIMEOUT - 1, the last wait count.
    localparam int unsigned WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StNext
    } state_e;

    state_e             state;
    logic [TILE_W-1:0]  tile_last;   // index of the final tile of this layer
    logic [DRAIN_W-1:0] drain_len;   // latched drain length, never 0
    logic [DRAIN_W-1:0] drain_cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            tile_last      <= '0;
            drain_len      <= DRAIN_W'(1);
            drain_cnt      <= DRAIN_W'(1);
            wait_cnt       <= '0;
            weight_start   <= 1'b0;
            img2col_start  <= 1'b0;
            array_valid_en <= 1'b0;
            busy           <= 1'b0;
            tile_idx       <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            weight_start <= 1'b0;
            done         <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start) begin
                        tile_last    <= (tile_count == '0) ? '0 : tile_count - TILE_W'(1);
                        drain_len    <= (drain_cycles == '0) ? DRAIN_W'(1) : drain_cycles;
                        tile_idx     <= '0;
                        error        <= 1'b0;
                        wait_cnt     <= '0;
                        weight_start <= 1'b1;
                        busy         <= 1'b1;
                        state        <= StLoadW;
                    end
                end

                StLoadW: begin
                    // Weights arriving on the final allowed cycle still count.
                    if (weight_cached) begin
                        img2col_start  <= 1'b1;
                        array_valid_en <= 1'b1;
                        state          <= StStream;
                    end else if (wait_cnt == WAIT_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                StStream: begin
                    if (layer_end) begin
                        drain_cnt      <= drain_len;
                        img2col_start  <= 1'b0;
                        array_valid_en <= 1'b0;
                        state          <= StDrain;
                    end
                end

                StDrain: begin
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state <= StNext;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end

                StNext: begin
                    if (tile_idx == tile_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        tile_idx     <= tile_idx + TILE_W'(1);
                        wait_cnt     <= '0;
                        weight_start <= 1'b1;
                        state        <= StLoadW;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase

            // A pass-complete pulse is only legal while streaming. It flags an
            // error but does not steer the state machine. Placed after the
            // case so it wins over the clear on a simultaneous start.
            if (layer_end && (state != StStream)) begin
                error <= 1'b1;
            end
        end
    end

`ifdef CONV_SEQ_PERF_CNT_EN
    // Saturating counters; they hold after done so software can read them
    // once the layer has finished.
    always_ff @(posedge clk) begin
        if (rst || ((state == StIdle) && start)) begin
            stall_cycles  <= '0;
            stream_cycles <= '0;
        end else begin
            if ((state == StLoadW) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state == StStream) && (stream_cycles != 32'hFFFF_FFFF)) begin
                stream_cycles <= stream_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sequencer
//
// Self-checking bench for conv_layer_sequencer. A layer-level model turns
// per-tile parameters (weight wait, stream length, drain length) into a
// cycle table. Each record holds the inputs for that cycle and the outputs
// expected during it. The table is then applied and compared in a loop. A
// mid-stream reset is exercised by a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_conv_layer_sequencer;

    localparam int unsigned TILE_W       = 8;
    localparam int unsigned DRAIN_W      = 16;
    localparam int unsigned WAIT_TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [TILE_W-1:0]  tile_count;
    logic [DRAIN_W-1:0] drain_cycles;
    logic               weight_start;
    logic               weight_cached;
    logic               img2col_start;
    logic               layer_end;
    logic               array_valid_en;
    logic               busy;
    logic [TILE_W-1:0]  tile_idx;
    logic               done;
    logic               error;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0]        stall_cycles;
    logic [31:0]        stream_cycles;
`endif

    conv_layer_sequencer #(
        .TILE_W       (TILE_W),
        .DRAIN_W      (DRAIN_W),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .tile_count     (tile_count),
        .drain_cycles   (drain_cycles),
        .weight_start   (weight_start),
        .weight_cached  (weight_cached),
        .img2col_start  (img2col_start),
        .layer_end      (layer_end),
        .array_valid_en (array_valid_en),
        .busy           (busy),
        .tile_idx       (tile_idx),
        .done           (done),
        .error          (error)
`ifdef CONV_SEQ_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .stream_cycles  (stream_cycles)
`endif
    );

    always #5 clk = ~clk;

    // e_out = {weight_start, img2col_start, array_valid_en, busy, done, error}
    typedef struct {
        bit                 start;
        logic [TILE_W-1:0]  tc;
        logic [DRAIN_W-1:0] dc;
        bit                 wc;
        bit                 le;
        bit [5:0]           e_out;
        bit                 chk_idx;
        logic [TILE_W-1:0]  e_idx;
        bit                 chk_perf;
        int unsigned        e_stall;
        int unsigned        e_stream;
    } vec_t;

    vec_t        tl[$];
    int          checks   = 0;
    int          failures = 0;
    bit          cur_err  = 1'b0;
    int          w_arr[16];      // LOAD_W cycles per tile; > WAIT_TIMEOUT means never ready
    int          s_arr[16];      // STREAM cycles per tile
    int unsigned m_stall;
    int unsigned m_stream;

    function automatic vec_t mk(bit ws, bit ic, bit ave, bit bsy, bit dn, bit err,
                                bit chk, int idx);
        vec_t r;
        r.start    = 1'b0;
        r.tc       = TILE_W'($urandom);
        r.dc       = DRAIN_W'($urandom);
        r.wc       = 1'($urandom);
        r.le       = 1'b0;
        r.e_out    = {ws, ic, ave, bsy, dn, err};
        r.chk_idx  = chk;
        r.e_idx    = TILE_W'(idx);
        r.chk_perf = 1'b0;
        r.e_stall  = 0;
        r.e_stream = 0;
        return r;
    endfunction

    // Busy cycles may carry a spurious start, which must be ignored.
    task automatic add_busy(vec_t r);
        if ($urandom_range(0, 7) == 0) r.start = 1'b1;
        tl.push_back(r);
    endtask

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) tl.push_back(mk(0, 0, 0, 0, 0, cur_err, 0, 0));
    endtask

    // Appends one layer to the table. merge places the start on the last
    // existing record (e.g. the done cycle). bad_tile >= 0 injects a stray
    // layer_end on the first weight-wait cycle of that tile.
    task automatic build_layer(int tc, int dc, bit merge, int bad_tile);
        vec_t r;
        int   eff_tc;
        int   eff_dc;
        int   nload;
        bit   to;
        eff_tc = (tc == 0) ? 1 : tc;
        eff_dc = (dc == 0) ? 1 : dc;
        if (merge && tl.size() > 0) begin
            r = tl.pop_back();
        end else begin
            r = mk(0, 0, 0, 0, 0, cur_err, 0, 0);
        end
        r.start = 1'b1;
        r.tc    = TILE_W'(tc);
        r.dc    = DRAIN_W'(dc);
        tl.push_back(r);
        cur_err  = 1'b0;
        m_stall  = 0;
        m_stream = 0;
        for (int i = 0; i < eff_tc; i++) begin
            to    = (w_arr[i] > int'(WAIT_TIMEOUT));
            nload = to ? int'(WAIT_TIMEOUT) : w_arr[i];
            for (int j = 0; j < nload; j++) begin
                r    = mk(j == 0, 0, 0, 1, 0, cur_err, 1, i);
                r.wc = !to && (j == nload - 1);
                r.le = (i == bad_tile) && (j == 0);
                add_busy(r);
                if (r.le) cur_err = 1'b1;
            end
            m_stall += nload;
            if (to) begin
                cur_err    = 1'b1;
                r          = mk(0, 0, 0, 0, 0, 1, 0, 0);
                r.chk_perf = 1'b1;
                r.e_stall  = m_stall;
                r.e_stream = m_stream;
                tl.push_back(r);
                return;
            end
            for (int j = 0; j < s_arr[i]; j++) begin
                r    = mk(0, 1, 1, 1, 0, cur_err, 1, i);
                r.le = (j == s_arr[i] - 1);
                if (i == 0 && j == 0) begin
                    r.start = 1'b1;
                    tl.push_back(r);
                end else begin
                    add_busy(r);
                end
            end
            m_stream += s_arr[i];
            for (int j = 0; j < eff_dc + 1; j++) add_busy(mk(0, 0, 0, 1, 0, cur_err, 1, i));
        end
        r          = mk(0, 0, 0, 0, 1, cur_err, 0, 0);
        r.chk_perf = 1'b1;
        r.e_stall  = m_stall;
        r.e_stream = m_stream;
        tl.push_back(r);
    endtask

    task automatic check_rec(string name, int k, vec_t r);
        bit [5:0] act;
        act = {weight_start, img2col_start, array_valid_en, busy, done, error};
        checks++;
        if (act !== r.e_out || (r.chk_idx && tile_idx !== r.e_idx)) begin
            failures++;
            $display("FAIL %s cyc%0d ws/ic/ave/busy/done/err got %b idx %0d, expected %b idx %0d",
                     name, k, act, tile_idx, r.e_out, r.e_idx);
        end
`ifdef CONV_SEQ_PERF_CNT_EN
        if (r.chk_perf) begin
            checks++;
            if (stall_cycles !== r.e_stall || stream_cycles !== r.e_stream) begin
                failures++;
                $display("FAIL %s_perf cyc%0d stall/stream got %0d/%0d, expected %0d/%0d",
                         name, k, stall_cycles, stream_cycles, r.e_stall, r.e_stream);
            end
        end
`endif
    endtask

    task automatic run_tl(string name);
        for (int k = 0; k < tl.size(); k++) begin
            @(negedge clk);
            check_rec(name, k, tl[k]);
            start         = tl[k].start;
            tile_count    = tl[k].tc;
            drain_cycles  = tl[k].dc;
            weight_cached = tl[k].wc;
            layer_end     = tl[k].le;
        end
        @(negedge clk);
        start     = 1'b0;
        layer_end = 1'b0;
        tl.delete();
    endtask

    task automatic check_zero(string name);
        checks++;
        if ({weight_start, img2col_start, array_valid_en, busy, done, error} !== 6'b0 ||
            tile_idx !== '0) begin
            failures++;
            $display("FAIL %s got ws/ic/ave/busy/done/err %b idx %0d, expected all 0",
                     name, {weight_start, img2col_start, array_valid_en, busy, done, error},
                     tile_idx);
        end
`ifdef CONV_SEQ_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0 || stream_cycles !== 32'd0) begin
            failures++;
            $display("FAIL %s_perf got %0d/%0d, expected 0/0", name, stall_cycles,
                     stream_cycles);
        end
`endif
    endtask

    initial begin
        bit found;
        int tc;
        rst           = 1'b1;
        start         = 1'b0;
        tile_count    = '0;
        drain_cycles  = '0;
        weight_cached = 1'b0;
        layer_end     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single tile: weights after 10 cycles, 51 streaming cycles, drain 4.
        w_arr[0] = 10;
        s_arr[0] = 51;
        build_layer(1, 4, 0, -1);
        push_idle(3);
        run_tl("single");

        // Five tiles, drain_cycles 0 behaves as 1.
        for (int i = 0; i < 5; i++) begin
            w_arr[i] = $urandom_range(1, 16);
            s_arr[i] = $urandom_range(1, 20);
        end
        build_layer(5, 0, 0, -1);
        push_idle(2);
        run_tl("five");

        // Weight timeout, then a new start clears the error.
        w_arr[0] = 100;
        build_layer(1, 3, 0, -1);
        push_idle(2);
        w_arr[0] = 1;
        s_arr[0] = 4;
        build_layer(1, 2, 0, -1);
        push_idle(2);
        run_tl("timeout");

        // Stray layer_end while waiting for weights.
        w_arr[0] = 6; s_arr[0] = 5;
        w_arr[1] = 2; s_arr[1] = 3;
        build_layer(2, 1, 0, 0);
        push_idle(2);
        run_tl("protocol");

        // Back-to-back layers: start on the done cycle; tile_count 0.
        for (int i = 0; i < 3; i++) begin
            w_arr[i] = $urandom_range(1, 5);
            s_arr[i] = $urandom_range(1, 6);
        end
        build_layer(2, 2, 0, -1);
        build_layer(0, 0, 1, -1);
        build_layer(3, 1, 1, -1);
        push_idle(2);
        run_tl("b2b");

        // Randomised layers against the model.
        for (int l = 0; l < 12; l++) begin
            tc = $urandom_range(0, 6);
            for (int i = 0; i < 6; i++) begin
                w_arr[i] = ($urandom_range(0, 15) == 0) ? 17 : $urandom_range(1, 16);
                s_arr[i] = $urandom_range(1, 12);
            end
            build_layer(tc, $urandom_range(0, 5), 1'($urandom),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1);
            push_idle($urandom_range(1, 3));
            run_tl("random");
        end

        // Reset in the middle of streaming tile 2; an in-flight layer_end is discarded.
        @(negedge clk);
        start         = 1'b1;
        tile_count    = TILE_W'(4);
        drain_cycles  = DRAIN_W'(2);
        weight_cached = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (img2col_start && tile_idx == TILE_W'(2)) begin
                found = 1'b1;
                break;
            end
            layer_end = img2col_start;
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_tile2 got timeout, expected streaming at tile 2");
        end
        rst       = 1'b1;
        layer_end = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst           = 1'b0;
        layer_end     = 1'b0;
        weight_cached = 1'b0;
        cur_err       = 1'b0;
        w_arr[0] = 2;
        s_arr[0] = 3;
        build_layer(1, 1, 0, -1);
        push_idle(2);
        run_tl("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
